next_pc_unit: RTL

- Parametrised program-counter block for the multicycle CPU.
- Holds the architectural PC register.
- Each advance, computes and commits one of four next-PC sources: sequential, conditional branch, region-concatenated jump, or jump-register.
- Also records the link address and flags misaligned register jumps.
- Sits between the control FSM (sel, pc_en) and the register file / IR.

---
 rtl/next_pc_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// Program-counter register with sequential, branch, jump and jump-register
// next-PC selection, link capture, misaligned-jr flag and redirect counter.
module next_pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SHIFT        = 2,
    parameter int unsigned REGION_BITS  = 4,
    parameter int unsigned IMM_BITS     = 26,
    parameter int unsigned BR_BITS      = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned COUNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pc_en,
    input  logic [1:0]            sel,
    input  logic                  branch_taken,
    input  logic [WIDTH-1:0]      ir_in,
    input  logic [WIDTH-1:0]      rs_in,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      pc_plus_out,
    output logic [WIDTH-1:0]      link_out,
    output logic                  misaligned_err,
    output logic [COUNT_BITS-1:0] redirect_cnt
);

    if (REGION_BITS + IMM_BITS + SHIFT != WIDTH) begin : g_bad_cfg
        $error("next_pc_unit: REGION_BITS+IMM_BITS+SHIFT must equal WIDTH");
    end

    localparam logic [WIDTH-1:0] INC = WIDTH'(1) << SHIFT;

    logic [WIDTH-1:0]      pc_q, pc_d;
    logic [WIDTH-1:0]      link_q, link_d;
    logic                  err_q, err_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic             jr_mis;
    logic             redirect;
    logic [WIDTH-1:0] tgt;

    // Upper IR bits above both immediate fields are decoded elsewhere.
    logic unused_ir;
    assign unused_ir = ^ir_in;

    assign pc_plus  = pc_q + INC;
    assign jump_tgt = {pc_plus[WIDTH-1 -: REGION_BITS],
                       ir_in[IMM_BITS-1:0], {SHIFT{1'b0}}};
    assign br_off   = WIDTH'($signed(ir_in[BR_BITS-1:0])) << SHIFT;
    assign br_tgt   = pc_plus + br_off;
    assign jr_mis   = |rs_in[SHIFT-1:0];

    always_comb begin
        redirect = 1'b0;
        tgt      = pc_plus;
        case (sel)
            2'd0: begin
                redirect = 1'b0;
                tgt      = pc_plus;
            end
            2'd1: begin
                redirect = branch_taken;
                tgt      = branch_taken ? br_tgt : pc_plus;
            end
            2'd2: begin
                redirect = 1'b1;
                tgt      = jump_tgt;
            end
            default: begin
                redirect = ~jr_mis;
                tgt      = jr_mis ? pc_q : rs_in;
            end
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        link_d = link_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (pc_en) begin
            pc_d = tgt;
            if (sel == 2'd3 && jr_mis) begin
                err_d = 1'b1;
            end
            if (redirect) begin
                link_d = pc_plus;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q   <= RESET_VECTOR;
            link_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            link_q <= link_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_plus_out    = pc_plus;
    assign link_out       = link_q;
    assign misaligned_err = err_q;
    assign redirect_cnt   = cnt_q;

endmodule
